// File: rtl/sar_search.sv
// sar_search: successive-approximation search engine.
// Drives a trial probe into an external comparator and walks MSB to LSB,
// using the eq/gt/lt verdicts to rebuild the comparator's hidden operand.
// Optional feature macro: SAR_SEARCH_TIMEOUT_EN (verdict-wait timeout).
module sar_search #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             cmp_valid,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // A verdict is usable only when exactly one of eq/gt/lt is set.
  function automatic logic verdict_onehot(input logic eq, input logic gt, input logic lt);
    logic ok;
    case ({eq, gt, lt})
      3'b100:  ok = 1'b1;
      3'b010:  ok = 1'b1;
      3'b001:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Single-bit mask at position idx.
  function automatic logic [WIDTH-1:0] bit_mask(input logic [IW-1:0] idx);
    return WIDTH'(1) << idx;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic             probe_valid_q, probe_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exact_q, exact_d;
  logic             err_q, err_d;
  logic             verdict_s;
  logic [WIDTH-1:0] acc_keep_s;

`ifdef SAR_SEARCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Outputs come straight from flops; no combinational input-to-output path.
  assign probe       = probe_q;
  assign probe_valid = probe_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign exact       = exact_q;
  assign err         = err_q;

  // Next-state and next-output computation for the search FSM.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    bit_idx_d     = bit_idx_q;
    probe_d       = probe_q;
    probe_valid_d = probe_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    result_d      = result_q;
    exact_d       = exact_q;
    err_d         = err_q;
    verdict_s     = probe_valid_q && cmp_valid;
    acc_keep_s    = cmp_gt ? probe_q : acc_q;
`ifdef SAR_SEARCH_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_PROBE;
          acc_d         = '0;
          bit_idx_d     = IW'(WIDTH - 1);
          probe_d       = bit_mask(IW'(WIDTH - 1));
          probe_valid_d = 1'b1;
          busy_d        = 1'b1;
          result_d      = '0;
          exact_d       = 1'b0;
          err_d         = 1'b0;
`ifdef SAR_SEARCH_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PROBE: begin
        if (verdict_s) begin
`ifdef SAR_SEARCH_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (!verdict_onehot(cmp_eq, cmp_gt, cmp_lt)) begin
            // Malformed verdict: keep the partial accumulator and bail out.
            state_d       = S_DONE;
            err_d         = 1'b1;
            probe_d       = '0;
            probe_valid_d = 1'b0;
            done_d        = 1'b1;
            result_d      = acc_q;
          end else if (cmp_eq) begin
            // Exact hit: the probe is the target, stop early.
            state_d       = S_DONE;
            acc_d         = probe_q;
            exact_d       = 1'b1;
            probe_d       = '0;
            probe_valid_d = 1'b0;
            done_d        = 1'b1;
            result_d      = probe_q;
          end else if (bit_idx_q == IW'(0)) begin
            // Last bit resolved without an eq.
            state_d       = S_DONE;
            acc_d         = acc_keep_s;
            probe_d       = '0;
            probe_valid_d = 1'b0;
            done_d        = 1'b1;
            result_d      = acc_keep_s;
          end else begin
            // gt keeps the trial bit, lt drops it; move to the next bit down.
            acc_d     = acc_keep_s;
            bit_idx_d = bit_idx_q - IW'(1);
            probe_d   = acc_keep_s | bit_mask(bit_idx_q - IW'(1));
          end
        end else begin
`ifdef SAR_SEARCH_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Comparator went silent: give up with the partial accumulator.
            state_d       = S_DONE;
            err_d         = 1'b1;
            probe_d       = '0;
            probe_valid_d = 1'b0;
            done_d        = 1'b1;
            result_d      = acc_q;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          state_d = S_PROBE;
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d       = S_IDLE;
        probe_d       = '0;
        probe_valid_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      bit_idx_q     <= '0;
      probe_q       <= '0;
      probe_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      exact_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      bit_idx_q     <= bit_idx_d;
      probe_q       <= probe_d;
      probe_valid_q <= probe_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      exact_q       <= exact_d;
      err_q         <= err_d;
    end
  end

`ifdef SAR_SEARCH_TIMEOUT_EN
  // Verdict-wait counter, cleared on each accepted verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search (WIDTH=8, TIMEOUT=15).
// A behavioural comparator answers probes; a reference SAR model pushes the
// expected probe sequence and final outcome into queues at start time.
module tb_sar_search;

  localparam int W  = 8;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] probe;
  logic         probe_valid;
  logic         cmp_valid = 1'b0;
  logic         cmp_eq = 1'b0;
  logic         cmp_gt = 1'b0;
  logic         cmp_lt = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         exact;
  logic         err;

  typedef struct {
    logic [W-1:0] res;
    logic         ex;
    logic         er;
    int           done_at;
  } exp_t;

  logic [W-1:0] exp_probes[$];
  exp_t         sb[$];

  int n_total = 0;
  int n_bad   = 0;

  sar_search #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .probe(probe), .probe_valid(probe_valid),
    .cmp_valid(cmp_valid), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .busy(busy), .done(done), .result(result), .exact(exact), .err(err)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference SAR: pushes expected probes and outcome.
  // lat = cycles each probe is held (0 = comparator never answers),
  // bad_at = 1-based probe index that gets a malformed verdict (0 = none).
  task automatic model_push(input logic [W-1:0] tgt, input int lat, input int bad_at);
    logic [W-1:0] acc;
    logic [W-1:0] p;
    logic         found;
    logic         er;
    int           n;
    exp_t         e;
    acc = '0; found = 1'b0; er = 1'b0; n = 0;
    if (lat == 0) begin
      exp_probes.push_back(8'd128);
      er = 1'b1;
      e.done_at = TO + 1;
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        p = acc | (8'd1 << i);
        exp_probes.push_back(p);
        n++;
        if (n == bad_at) begin
          er = 1'b1;
          break;
        end
        if (tgt == p) begin
          found = 1'b1;
          acc = p;
          break;
        end
        if (tgt > p) acc = p;
      end
      e.done_at = n * lat + 1;
    end
    e.res = acc; e.ex = found; e.er = er;
    sb.push_back(e);
  endtask

  // Run one search against a comparator holding tgt.
  task automatic do_search(input logic [W-1:0] tgt, input int lat, input int bad_at);
    int           cyc;
    int           hold;
    int           pidx;
    logic [W-1:0] cur;
    logic         seen_done;
    exp_t         e;
    model_push(tgt, lat, bad_at);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; hold = 0; pidx = 0; cur = '0; seen_done = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("pv_rise", {31'd0, probe_valid}, 32'd1);
    while (cyc < 200) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      cmp_valid = 1'b0; cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0;
      if (probe_valid) begin
        if (hold == 0) begin
          if (exp_probes.size() == 0) begin
            check("probe_extra", 32'd1, 32'd0);
            break;
          end
          cur = exp_probes.pop_front();
          pidx++;
          check($sformatf("probe%0d", pidx), {24'd0, probe}, {24'd0, cur});
        end else begin
          check("probe_hold", {24'd0, probe}, {24'd0, cur});
        end
        hold++;
        if (lat > 0 && hold >= lat) begin
          cmp_valid = 1'b1;
          if (pidx == bad_at) begin
            cmp_gt = 1'b1; cmp_lt = 1'b1;
          end else begin
            cmp_eq = (tgt == probe);
            cmp_gt = (tgt > probe);
            cmp_lt = (tgt < probe);
          end
          hold = 0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    cmp_valid = 1'b0; cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0;
    check("done_seen", {31'd0, seen_done}, 32'd1);
    e = sb.pop_front();
    check("done_cycle", cyc, e.done_at);
    check("result", {24'd0, result}, {24'd0, e.res});
    check("exact", {31'd0, exact}, {31'd0, e.ex});
    check("err", {31'd0, err}, {31'd0, e.er});
    check("probes_left", exp_probes.size(), 32'd0);
    exp_probes.delete();
    // start during the DONE cycle must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_drop", {31'd0, busy}, 32'd0);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("pv_idle", {31'd0, probe_valid}, 32'd0);
    check("result_hold", {24'd0, result}, {24'd0, e.res});
  endtask

  // Check every output is at its reset value.
  task automatic check_reset_outs(input string tag);
    check({tag, "_probe"}, {24'd0, probe}, 32'd0);
    check({tag, "_pv"}, {31'd0, probe_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_result"}, {24'd0, result}, 32'd0);
    check({tag, "_exact"}, {31'd0, exact}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  // Main sequence.
  initial begin
    #1;
    check_reset_outs("rst0");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_search(8'd15, 1, 0);
    do_search(8'd128, 1, 0);
    do_search(8'd0, 1, 0);
    do_search(8'd255, 3, 0);
    do_search(8'd200, 1, 2);
    do_search(8'd93, 2, 0);
    do_search(8'd1, 1, 0);

    // reset mid-search after a search that left result/exact set
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp_valid = 1'b1;
      cmp_eq = (8'd77 == probe); cmp_gt = (8'd77 > probe); cmp_lt = (8'd77 < probe);
      @(posedge clk); #1;
    end
    cmp_valid = 1'b0; cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    do_search(8'd77, 1, 0);

`ifdef SAR_SEARCH_TIMEOUT_EN
    do_search(8'd77, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
